// File: rtl/ram_bus_ctrl_pkg.sv
// rtl/ram_bus_ctrl_pkg.sv - shared state encoding and byte-lane constants for the RAM bus controller
package ram_bus_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    MERGE = 3'd2,
    WR    = 3'd3,
    RESP  = 3'd4
  } state_e;

  localparam int              BYTE_LANES = 4;
  localparam logic [BYTE_LANES-1:0] ALL_LANES = 4'hF;

endpackage

// File: rtl/ram_bus_ctrl_if.sv
// rtl/ram_bus_ctrl_if.sv - core request/response handshake and RAM address/control pins
interface ram_bus_ctrl_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  import ram_bus_ctrl_pkg::*;

  logic                    req_valid;
  logic                    req_ready;
  logic                    req_we;
  logic [31:0]             req_addr;
  logic [BYTE_LANES-1:0]   req_be;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic                    resp_valid;
  logic [DATA_WIDTH-1:0]   resp_rdata;
  logic                    resp_err;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic                    mem_r_w;
  logic                    mem_cs;

  modport master (
    output req_valid, req_we, req_addr, req_be, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_addr, mem_r_w, mem_cs
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_be, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_addr, mem_r_w, mem_cs
  );

endinterface

// File: rtl/ram_bus_ctrl_byte_lane_merge.sv
// rtl/ram_bus_ctrl_byte_lane_merge.sv - combinational byte-lane merge for read-modify-write stores
module byte_lane_merge
  import ram_bus_ctrl_pkg::*;
(
  input  logic [31:0]           old_word,
  input  logic [31:0]           new_word,
  input  logic [BYTE_LANES-1:0] be,
  output logic [31:0]           merged
);

  always_comb begin
    merged = old_word;
    for (int i = 0; i < BYTE_LANES; i++) begin
      if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
  end

endmodule

// File: rtl/ram_bus_ctrl.sv
// rtl/ram_bus_ctrl.sv - sequences the 4Kx32 tri-state RAM for core loads, full stores and RMW partial stores
module ram_bus_ctrl
  import ram_bus_ctrl_pkg::*;
#(
  parameter int          ADDR_WIDTH = 12,
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                  CLK,
  input  logic                  Rst,
  ram_bus_ctrl_if.slave         bus,
  inout  wire  [DATA_WIDTH-1:0] mem_data
);

  localparam logic [31:0] LAST_OFFSET = 32'((64'd1 << (ADDR_WIDTH + 2)) - 64'd1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [BYTE_LANES-1:0] be_q, be_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           old_q, old_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic [31:0] offset;
  logic        req_bad;
  logic [31:0] merged;

  // Addresses below BASE_ADDR wrap to a huge offset and fail the same range check.
  assign offset  = bus.req_addr - BASE_ADDR;
  assign req_bad = (offset > LAST_OFFSET) || (bus.req_be == '0);

  byte_lane_merge u_merge (
    .old_word (old_q),
    .new_word (wdata_q),
    .be       (be_q),
    .merged   (merged)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    old_d   = old_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          addr_d  = offset[ADDR_WIDTH+1:2];
          we_d    = bus.req_we;
          be_d    = bus.req_be;
          wdata_d = bus.req_wdata;
          if (req_bad) begin
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = RESP;
          end else if (bus.req_we && bus.req_be == ALL_LANES) begin
            state_d = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: begin
        if (we_q) begin
          old_d   = mem_data;
          state_d = MERGE;
        end else begin
          rdata_d = mem_data;
          err_d   = 1'b0;
          state_d = RESP;
        end
      end
      MERGE: begin
        wdata_d = merged;
        state_d = WR;
      end
      WR: begin
        rdata_d = '0;
        err_d   = 1'b0;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      old_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      old_q   <= old_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Bus pins decode only from registered state, so reset releases the bus immediately.
  assign mem_data       = (state_q == WR) ? wdata_q : 'z;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_cs     = (state_q == RD) || (state_q == WR);
  assign bus.mem_r_w    = (state_q != WR);
  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_ram_bus_ctrl.sv
// tb/tb_ram_bus_ctrl.sv - directed self-checking bench for ram_bus_ctrl with a behavioural tri-state RAM
module tb_ram_bus_ctrl;
  import ram_bus_ctrl_pkg::*;

  localparam logic [31:0] PROBE = 32'hA5A5_A5A5;

  logic CLK = 1'b0;
  logic Rst = 1'b1;
  always #5 CLK = ~CLK;

  wire [31:0] mem_data;
  ram_bus_ctrl_if bus ();

  ram_bus_ctrl dut (
    .CLK      (CLK),
    .Rst      (Rst),
    .bus      (bus.slave),
    .mem_data (mem_data)
  );

  logic [31:0] ram [0:4095];
  logic        probe = 1'b0;

  // RAM drives during reads; a weak-intent probe pattern shows whether anyone else is driving.
  assign mem_data = (bus.mem_cs && bus.mem_r_w) ? ram[bus.mem_addr] : 'z;
  assign mem_data = probe ? PROBE : 'z;

  always @(posedge CLK) begin
    if (bus.mem_cs && !bus.mem_r_w) ram[bus.mem_addr] <= mem_data;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wd, output logic [31:0] rdata, output logic err,
                        output int lat, output logic [31:0] pat, output logic [11:0] maddr,
                        output int bus_bad);
    logic got_addr;
    @(negedge CLK);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_be    = be;
    bus.req_wdata = wd;
    @(posedge CLK);
    @(negedge CLK);
    bus.req_valid = 1'b0;
    bus.req_addr  = 32'hFFFF_FFF0;
    bus.req_wdata = 32'h0BAD_0BAD;
    lat = 0; pat = '0; maddr = '0; bus_bad = 0; rdata = '0; err = 1'b0; got_addr = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (i > 1) @(negedge CLK);
      pat = {pat[29:0], bus.mem_cs, ~bus.mem_r_w};
      if (bus.mem_cs && !got_addr) begin
        maddr    = bus.mem_addr;
        got_addr = 1'b1;
      end
      if (!bus.mem_cs) begin
        probe = 1'b1;
        #1;
        if (mem_data !== PROBE) bus_bad++;
        probe = 1'b0;
      end
      if (bus.resp_valid) begin
        lat   = i;
        rdata = bus.resp_rdata;
        err   = bus.resp_err;
        break;
      end
    end
  endtask

  logic [31:0] r, pat;
  logic        e, resp_seen;
  int          lat, bb;
  logic [11:0] ma;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = '0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_be    = '0;
    bus.req_wdata = '0;

    @(negedge CLK);
    chk("rst_ready", bus.req_ready, 1);
    chk("rst_cs", bus.mem_cs, 0);
    chk("rst_rw", bus.mem_r_w, 1);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_rdata", bus.resp_rdata, 0);
    chk("rst_err", bus.resp_err, 0);
    chk("rst_addr", bus.mem_addr, 0);
    probe = 1'b1; #1;
    chk("rst_bus_hiz", mem_data, PROBE);
    probe = 1'b0;
    Rst = 1'b0;
    @(negedge CLK);
    chk("idle_ready", bus.req_ready, 1);

    do_req(1, 32'h10, 4'hF, 32'hDEADBEEF, r, e, lat, pat, ma, bb);
    chk("st_err", e, 0); chk("st_lat", lat, 2); chk("st_pat", pat, 32'hC);
    chk("st_addr", ma, 4); chk("st_rdata", r, 0);

    do_req(0, 32'h10, 4'hF, 0, r, e, lat, pat, ma, bb);
    chk("ld_rdata", r, 32'hDEADBEEF); chk("ld_err", e, 0); chk("ld_lat", lat, 2);
    chk("ld_pat", pat, 32'h8); chk("ld_addr", ma, 4); chk("ld_bus", bb, 0);
    @(negedge CLK);
    chk("hold_rdata", bus.resp_rdata, 32'hDEADBEEF);
    chk("hold_valid", bus.resp_valid, 0);

    do_req(1, 32'h10, 4'hF, 32'h11223344, r, e, lat, pat, ma, bb);
    do_req(1, 32'h10, 4'b0101, 32'hAABBCCDD, r, e, lat, pat, ma, bb);
    chk("pst_lat", lat, 4); chk("pst_pat", pat, 32'h8C); chk("pst_bus", bb, 0);
    chk("pst_err", e, 0); chk("pst_rdata", r, 0);
    do_req(0, 32'h10, 4'hF, 0, r, e, lat, pat, ma, bb);
    chk("pst_merged", r, 32'h11BB33DD);

    do_req(0, 32'h4000, 4'hF, 0, r, e, lat, pat, ma, bb);
    chk("oob_err", e, 1); chk("oob_rdata", r, 0); chk("oob_pat", pat, 0); chk("oob_lat", lat, 1);
    do_req(0, 32'hFFFF_FFFC, 4'hF, 0, r, e, lat, pat, ma, bb);
    chk("wrap_err", e, 1); chk("wrap_pat", pat, 0);

    do_req(1, 32'h3FFC, 4'hF, 32'hCAFEF00D, r, e, lat, pat, ma, bb);
    chk("top_st_addr", ma, 12'hFFF); chk("top_st_err", e, 0);
    do_req(0, 32'h3FFC, 4'hF, 0, r, e, lat, pat, ma, bb);
    chk("top_ld_rdata", r, 32'hCAFEF00D); chk("top_ld_err", e, 0); chk("top_ld_addr", ma, 12'hFFF);
    do_req(0, 32'h0, 4'hF, 0, r, e, lat, pat, ma, bb);
    chk("w0_err", e, 0); chk("w0_addr", ma, 0); chk("w0_rdata", r, 0);

    do_req(1, 32'h10, 4'h0, 32'h0, r, e, lat, pat, ma, bb);
    chk("be0_err", e, 1); chk("be0_pat", pat, 0);
    do_req(0, 32'h10, 4'hF, 0, r, e, lat, pat, ma, bb);
    chk("be0_unchanged", r, 32'h11BB33DD);

    // Reset while the write word is on the bus.
    @(negedge CLK);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'h20;
    bus.req_be = 4'hF; bus.req_wdata = 32'h12345678;
    @(posedge CLK);
    #1;
    chk("wr_entered", {bus.mem_cs, bus.mem_r_w}, 2'b10);
    #1;
    Rst = 1'b1;
    bus.req_valid = 1'b0;
    #1;
    probe = 1'b1; #1;
    chk("rst_wr_bus_hiz", mem_data, PROBE);
    probe = 1'b0;
    chk("rst_wr_cs", bus.mem_cs, 0);
    chk("rst_wr_rw", bus.mem_r_w, 1);
    @(negedge CLK);
    Rst = 1'b0;
    do_req(0, 32'h20, 4'hF, 0, r, e, lat, pat, ma, bb);
    chk("rst_wr_ram", r, 0);

    // Reset during the MERGE turnaround of a partial store.
    do_req(1, 32'h1C, 4'hF, 32'h55555555, r, e, lat, pat, ma, bb);
    @(negedge CLK);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'h1C;
    bus.req_be = 4'b0011; bus.req_wdata = 32'hFFFFFFFF;
    @(posedge CLK);
    @(negedge CLK);
    bus.req_valid = 1'b0;
    chk("rmw_rd", {bus.mem_cs, bus.mem_r_w}, 2'b11);
    @(posedge CLK);
    #1;
    chk("rmw_merge", {bus.mem_cs, bus.mem_r_w}, 2'b01);
    #1;
    Rst = 1'b1;
    resp_seen = 1'b0;
    repeat (2) begin
      @(negedge CLK);
      resp_seen |= bus.resp_valid;
    end
    Rst = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      resp_seen |= bus.resp_valid;
    end
    chk("rst_merge_no_resp", resp_seen, 0);
    do_req(0, 32'h1C, 4'hF, 0, r, e, lat, pat, ma, bb);
    chk("rst_merge_ram", r, 32'h55555555);
    chk("rst_merge_next_err", e, 0);
    chk("rst_merge_next_lat", lat, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
